// File: rtl/cnn_io_pkg.sv
// Shared constants, FSM state type and pixel slice helper for the CNN input loader.
package cnn_io_pkg;
  localparam int DATA_W     = 16;
  localparam int NUM_PIXELS = 64;
  localparam int FRAME_W    = DATA_W * NUM_PIXELS;
  localparam int PIX_CNT_W  = $clog2(NUM_PIXELS);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  // Low bit of pixel k in the frame bus; pixel 0 occupies the MSBs.
  function automatic int pix_lo(input int k);
    return FRAME_W - (k + 1) * DATA_W;
  endfunction
endpackage

// File: rtl/cnn_frame_fill.sv
// Pixel stream collector: beat counter, s_last framing check and the fill buffer.
module cnn_frame_fill
  import cnn_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  input  logic               take,
  output logic               s_ready,
  output logic               fill_full,
  output logic [FRAME_W-1:0] fill_data,
  output logic               err_pulse
);
  logic [PIX_CNT_W-1:0] cnt_reg;
  logic                 full_reg;
  logic [FRAME_W-1:0]   buf_reg;
  logic                 accept;
  logic                 at_end;

  // Gated by reset so the upstream never sees ready while the loader is held.
  assign s_ready   = rst_n && !full_reg;
  assign accept    = s_valid && s_ready;
  assign at_end    = (cnt_reg == PIX_CNT_W'(NUM_PIXELS - 1));
  assign err_pulse = accept && (at_end ? !s_last : s_last);
  assign fill_full = full_reg;
  assign fill_data = buf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      full_reg <= 1'b0;
      buf_reg  <= '0;
    end else begin
      if (take)
        full_reg <= 1'b0;
      if (accept) begin
        buf_reg[pix_lo(int'(cnt_reg)) +: DATA_W] <= s_data;
        if (at_end) begin
          cnt_reg  <= '0;
          full_reg <= 1'b1;
        end else if (s_last) begin
          // Early s_last: drop the partial frame and restart at pixel 0.
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cnn_input_loader.sv
// Frame loader for the CNN core: hold register, ap_ctrl_hs FSM, frame counter
// and sticky framing error on top of the fill buffer.
module cnn_input_loader
  import cnn_io_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic               err_clr,
  output logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  output logic [FRAME_W-1:0] conv2d_1_input_V,
  output logic               conv2d_1_input_V_ap_vld,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_count,
  output logic               frame_err
);
  logic               fill_full;
  logic               err_pulse;
  logic [FRAME_W-1:0] fill_data;
  logic               transfer;
  logic               rel_hold;
  logic [FRAME_W-1:0] hold_reg;
  logic               hold_valid_reg;
  logic               start_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   count_reg;
  state_t             state_reg;
  state_t             state_next;

  cnn_frame_fill u_fill (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .take      (transfer),
    .s_ready   (s_ready),
    .fill_full (fill_full),
    .fill_data (fill_data),
    .err_pulse (err_pulse)
  );

  // A frame released this cycle frees the hold register for the waiting one.
  assign transfer = fill_full && (!hold_valid_reg || rel_hold);

  always_comb begin
    state_next = state_reg;
    rel_hold   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_valid_reg)
          state_next = START;
      end
      START: begin
        if (ap_ready) begin
          state_next = ap_done ? IDLE : WAIT_DONE;
          rel_hold   = ap_done;
        end
      end
      WAIT_DONE: begin
        if (ap_done) begin
          state_next = IDLE;
          rel_hold   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg      <= IDLE;
      start_reg      <= 1'b0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_reg <= (state_next == START);
      if (transfer) begin
        hold_reg       <= fill_data;
        hold_valid_reg <= 1'b1;
      end else if (rel_hold) begin
        hold_valid_reg <= 1'b0;
      end
      if (rel_hold)
        count_reg <= count_reg + 1'b1;
      if (err_pulse)
        err_reg <= 1'b1;
      else if (err_clr)
        err_reg <= 1'b0;
    end
  end

  assign ap_start                = start_reg;
  assign conv2d_1_input_V_ap_vld = start_reg;
  assign conv2d_1_input_V        = hold_reg;
  assign busy                    = hold_valid_reg;
  assign frame_count             = count_reg;
  assign frame_err               = err_reg;
endmodule

// File: tb/tb_cnn_input_loader.sv
// Directed bench for cnn_input_loader: streams frames, plays the core's
// handshake and compares the frame bus, handshake timing and counters.
module tb_cnn_input_loader;
  import cnn_io_pkg::*;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [DATA_W-1:0]  s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               s_last = 1'b0;
  logic               err_clr = 1'b0;
  logic               ap_start;
  logic               ap_ready = 1'b0;
  logic               ap_done = 1'b0;
  logic [FRAME_W-1:0] conv2d_1_input_V;
  logic               conv2d_1_input_V_ap_vld;
  logic               busy;
  logic [15:0]        frame_count;
  logic               frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  cnn_input_loader #(.CNT_W(16)) dut (
    .ap_clk                  (ap_clk),
    .ap_rst_n                (ap_rst_n),
    .s_data                  (s_data),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .s_last                  (s_last),
    .err_clr                 (err_clr),
    .ap_start                (ap_start),
    .ap_ready                (ap_ready),
    .ap_done                 (ap_done),
    .conv2d_1_input_V        (conv2d_1_input_V),
    .conv2d_1_input_V_ap_vld (conv2d_1_input_V_ap_vld),
    .busy                    (busy),
    .frame_count             (frame_count),
    .frame_err               (frame_err)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame 0 is the k/8 ramp; other ids give a distinct per-pixel pattern.
  function automatic logic [DATA_W-1:0] pix(input int id, input int k);
    if (id == 0) return DATA_W'(k / 8);
    return DATA_W'(id * 1031 + k * 37 + (k << 9));
  endfunction

  function automatic logic [FRAME_W-1:0] frame_of(input int id);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_PIXELS; k++)
      f[FRAME_W-1-k*DATA_W -: DATA_W] = pix(id, k);
    return f;
  endfunction

  // Reports the first differing pixel (or pixel 0 when the buses agree).
  task automatic check_bus(input string tag, input logic [FRAME_W-1:0] got,
                           input logic [FRAME_W-1:0] exp);
    int idx = 0;
    bit found = 0;
    for (int k = 0; k < NUM_PIXELS; k++)
      if (!found && got[FRAME_W-1-k*DATA_W -: DATA_W] !== exp[FRAME_W-1-k*DATA_W -: DATA_W]) begin
        idx = k;
        found = 1;
      end
    check_val($sformatf("%s_bus_pix%0d", tag, idx),
              64'(got[FRAME_W-1-idx*DATA_W -: DATA_W]),
              64'(exp[FRAME_W-1-idx*DATA_W -: DATA_W]));
  endtask

  // Returns at the falling edge after the last accepted beat, s_valid dropped.
  task automatic send_frame(input int id, input int n_beats, input int last_at, input int gap_pct);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < n_beats && guard < 5000) begin
      @(negedge ap_clk);
      guard++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = pix(id, k);
        s_last  = (k == last_at);
      end
      acc = s_valid && s_ready;
      @(posedge ap_clk);
      if (acc) k++;
    end
    @(negedge ap_clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (k < n_beats) check_val("stream_timeout", 64'(k), 64'(n_beats));
    $display("sent frame id=%0d beats=%0d", id, k);
  endtask

  // Core model: waits for ap_start, checks the frame, acknowledges, completes.
  task automatic core_serve(input logic [FRAME_W-1:0] exp, input int rdy_dly,
                            input int done_dly, input bit same, input string tag);
    int guard = 0;
    while (!ap_start && guard < 2000) begin
      @(negedge ap_clk);
      guard++;
    end
    if (!ap_start) begin
      check_val({tag, "_start_timeout"}, 64'(ap_start), 64'd1);
      return;
    end
    check_bus(tag, conv2d_1_input_V, exp);
    check_val({tag, "_vld"}, 64'(conv2d_1_input_V_ap_vld), 64'd1);
    repeat (rdy_dly) @(negedge ap_clk);
    check_val({tag, "_start_held"}, 64'(ap_start), 64'd1);
    ap_ready = 1'b1;
    ap_done  = same;
    @(negedge ap_clk);
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    check_val({tag, "_start_drop"}, 64'(ap_start), 64'd0);
    if (!same) begin
      repeat (done_dly) @(negedge ap_clk);
      check_bus({tag, "_stable"}, conv2d_1_input_V, exp);
      ap_done = 1'b1;
      @(negedge ap_clk);
      ap_done = 1'b0;
    end
    $display("core served %s count=%0d", tag, frame_count);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; err_clr = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check_val({tag, "_ap_start"}, 64'(ap_start), 64'd0);
    check_val({tag, "_ap_vld"}, 64'(conv2d_1_input_V_ap_vld), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_count"}, 64'(frame_count), 64'd0);
    check_val({tag, "_err"}, 64'(frame_err), 64'd0);
    check_bus(tag, conv2d_1_input_V, '0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge ap_clk);
    check_all_zero("rst");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_val("rst_rel_s_ready", 64'(s_ready), 64'd1);

    // 1: ramp frame, start latency E+2
    send_frame(0, 64, 63, 0);
    check_val("t1_e0_start", 64'(ap_start), 64'd0);
    check_val("t1_e0_busy", 64'(busy), 64'd0);
    check_val("t1_e0_s_ready", 64'(s_ready), 64'd0);
    @(negedge ap_clk);
    check_val("t1_e1_start", 64'(ap_start), 64'd0);
    check_val("t1_e1_busy", 64'(busy), 64'd1);
    check_val("t1_e1_s_ready", 64'(s_ready), 64'd1);
    @(negedge ap_clk);
    check_val("t1_e2_start", 64'(ap_start), 64'd1);
    core_serve(frame_of(0), 1, 3, 1'b0, "t1");
    check_val("t1_count", 64'(frame_count), 64'd1);
    check_val("t1_busy_end", 64'(busy), 64'd0);
    check_val("t1_err", 64'(frame_err), 64'd0);

    // 2: frame B fills while A waits for ap_done
    do_reset();
    send_frame(1, 64, 63, 0);
    fork
      core_serve(frame_of(1), 1, 100, 1'b0, "t2a");
      begin
        send_frame(2, 64, 63, 0);
        check_val("t2_b_s_ready", 64'(s_ready), 64'd0);
        check_val("t2_b_count", 64'(frame_count), 64'd0);
      end
    join
    check_val("t2_rel_count", 64'(frame_count), 64'd1);
    check_val("t2_rel_busy", 64'(busy), 64'd1);
    check_val("t2_rel_start", 64'(ap_start), 64'd0);
    @(negedge ap_clk);
    check_val("t2_b_start", 64'(ap_start), 64'd1);
    core_serve(frame_of(2), 0, 2, 1'b0, "t2b");
    check_val("t2_count", 64'(frame_count), 64'd2);

    // 3: early s_last drops the frame and latches frame_err
    do_reset();
    send_frame(3, 11, 10, 0);
    check_val("t3_err", 64'(frame_err), 64'd1);
    repeat (5) @(negedge ap_clk);
    check_val("t3_no_start", 64'(ap_start), 64'd0);
    check_val("t3_no_busy", 64'(busy), 64'd0);
    send_frame(4, 64, 63, 0);
    core_serve(frame_of(4), 1, 2, 1'b0, "t3");
    check_val("t3_count", 64'(frame_count), 64'd1);
    check_val("t3_err_sticky", 64'(frame_err), 64'd1);
    err_clr = 1'b1;
    @(negedge ap_clk);
    err_clr = 1'b0;
    check_val("t3_err_clr", 64'(frame_err), 64'd0);

    // 4: ap_ready and ap_done in the first ap_start cycle
    do_reset();
    send_frame(5, 64, 63, 0);
    core_serve(frame_of(5), 0, 0, 1'b1, "t4");
    check_val("t4_busy", 64'(busy), 64'd0);
    check_val("t4_count", 64'(frame_count), 64'd1);
    @(negedge ap_clk);
    check_val("t4_no_restart", 64'(ap_start), 64'd0);

    // 5: asynchronous reset in WAIT_DONE with a half-filled buffer
    send_frame(6, 64, 63, 0);
    repeat (2) @(negedge ap_clk);
    check_val("t5_start", 64'(ap_start), 64'd1);
    ap_ready = 1'b1;
    @(negedge ap_clk);
    ap_ready = 1'b0;
    send_frame(7, 32, 63, 0);
    ap_rst_n = 1'b0;
    #1;
    check_all_zero("t5_rst");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    send_frame(8, 64, 63, 0);
    core_serve(frame_of(8), 1, 4, 1'b0, "t5");
    check_val("t5_count", 64'(frame_count), 64'd1);

    // 6: twenty frames with random idle beats and core timing
    do_reset();
    fork
      for (int i = 0; i < 20; i++) send_frame(100 + i, 64, 63, 30);
      for (int i = 0; i < 20; i++)
        core_serve(frame_of(100 + i), int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                   ($urandom_range(0, 3) == 0), $sformatf("t6_f%0d", i));
    join
    check_val("t6_count", 64'(frame_count), 64'd20);
    check_val("t6_err", 64'(frame_err), 64'd0);
    check_val("t6_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
